ofms_drain_serializer: RTL and testbench



---
 rtl/ofms_drain_serializer.sv | 123 ++++++++++++
 tb/tb_ofms_drain_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ofms_drain_serializer.sv
// Snapshot-and-drain serializer for the accumulated OFMS shift buffer.
// Optional macro OFMS_DRAIN_RELU_EN clamps negative pixels to zero on the beat output.
module ofms_drain_serializer #(
    parameter int VALID_CORE_NUM    = 16,
    parameter int FMS_PATCH_SIZE    = 8,
    parameter int OUTPUT_DATA_WIDTH = 20,
    parameter int OUT_BEAT_PIX      = 8,
    localparam int CORE_W = (VALID_CORE_NUM > 1) ? $clog2(VALID_CORE_NUM) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clk_en,
    input  logic                                   start,
    input  logic [VALID_CORE_NUM*FMS_PATCH_SIZE*FMS_PATCH_SIZE*OUTPUT_DATA_WIDTH-1:0] din,
    output logic                                   busy,
    output logic                                   clr_req,
    output logic                                   dout_valid,
    input  logic                                   dout_ready,
    output logic [OUT_BEAT_PIX*OUTPUT_DATA_WIDTH-1:0] dout_data,
    output logic [CORE_W-1:0]                      dout_core,
    output logic                                   dout_last,
    output logic                                   done
);

    localparam int W              = OUTPUT_DATA_WIDTH;
    localparam int PIX_PER_CORE   = FMS_PATCH_SIZE * FMS_PATCH_SIZE;
    localparam int BEATS_PER_CORE = PIX_PER_CORE / OUT_BEAT_PIX;
    localparam int N_BEATS        = VALID_CORE_NUM * BEATS_PER_CORE;
    localparam int BEAT_W         = OUT_BEAT_PIX * W;
    localparam int CNT_W          = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    generate
        if ((PIX_PER_CORE % OUT_BEAT_PIX) != 0) begin : g_bad_cfg
            $error("OUT_BEAT_PIX must divide FMS_PATCH_SIZE*FMS_PATCH_SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BEAT_W-1:0]  snap [N_BEATS];
    logic [CNT_W-1:0]   cnt_nxt;
    logic               cnt_is_last;

    assign cnt_nxt     = cnt + 1'b1;
    assign cnt_is_last = (cnt == CNT_W'(N_BEATS - 1));

    function automatic logic [BEAT_W-1:0] shape(input logic [BEAT_W-1:0] beat);
        logic [BEAT_W-1:0] r;
        r = beat;
`ifdef OFMS_DRAIN_RELU_EN
        for (int i = 0; i < OUT_BEAT_PIX; i++) begin
            if (beat[i*W + W - 1]) begin
                r[i*W +: W] = '0;
            end
        end
`endif
        return r;
    endfunction

    // Snapshot is a plain load-enabled register; it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && clk_en && (state == StIdle) && start) begin
            for (int i = 0; i < N_BEATS; i++) begin
                snap[i] <= din[i*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            busy       <= 1'b0;
            clr_req    <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            done       <= 1'b0;
            dout_data  <= '0;
            dout_core  <= '0;
        end else if (clk_en) begin
            clr_req <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        // Beat 0 comes straight from din so it is valid the cycle after start.
                        state      <= StStream;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        clr_req    <= 1'b1;
                        dout_valid <= 1'b1;
                        dout_data  <= shape(din[BEAT_W-1:0]);
                        dout_core  <= '0;
                        dout_last  <= (N_BEATS == 1);
                    end
                end
                StStream: begin
                    if (dout_ready) begin
                        if (cnt_is_last) begin
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            done       <= 1'b1;
                            state      <= StDone;
                        end else begin
                            cnt       <= cnt_nxt;
                            dout_data <= shape(snap[cnt_nxt]);
                            dout_core <= CORE_W'(int'(cnt_nxt) / BEATS_PER_CORE);
                            dout_last <= (cnt_nxt == CNT_W'(N_BEATS - 1));
                        end
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ofms_drain_serializer.sv
// Randomized bench for ofms_drain_serializer against a pixel-array reference model.
// Honours OFMS_DRAIN_RELU_EN in the model when defined.
module tb_ofms_drain_serializer;

    localparam int NC   = 16;
    localparam int P    = 8;
    localparam int W    = 20;
    localparam int BP   = 8;
    localparam int NPIX = NC * P * P;
    localparam int NB   = NPIX / BP;
    localparam int BPC  = (P * P) / BP;
    localparam int BW   = BP * W;

    logic              clk = 1'b0;
    logic              rst, clk_en, start, dout_ready;
    logic [NPIX*W-1:0] din;
    logic              busy, clr_req, dout_valid, dout_last, done;
    logic [BW-1:0]     dout_data;
    logic [3:0]        dout_core;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] pix [NPIX];

    ofms_drain_serializer #(
        .VALID_CORE_NUM   (NC),
        .FMS_PATCH_SIZE   (P),
        .OUTPUT_DATA_WIDTH(W),
        .OUT_BEAT_PIX     (BP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .start     (start),
        .din       (din),
        .busy      (busy),
        .clr_req   (clr_req),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data),
        .dout_core (dout_core),
        .dout_last (dout_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] exp_beat(input int k);
        logic [BW-1:0] b;
        logic [W-1:0]  p;
        b = '0;
        for (int i = 0; i < BP; i++) begin
            p = pix[k*BP + i];
`ifdef OFMS_DRAIN_RELU_EN
            if ($signed(p) < 0) p = '0;
`endif
            b[i*W +: W] = p;
        end
        return b;
    endfunction

    task automatic load_din();
        for (int n = 0; n < NPIX; n++) din[n*W +: W] = pix[n];
    endtask

    task automatic rand_pix();
        for (int n = 0; n < NPIX; n++) pix[n] = W'($urandom);
    endtask

    // Called on a negedge; leaves the bench on the negedge showing beat 0.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready high; mode 1: ready 1,0,0,1; mode 2: ready high, stray start at
    // beat 40 and clk_en low for 5 cycles at beat 60. Returns early when beat stop_at is seen.
    task automatic drain(input int mode, input int stop_at, output int cyc);
        int  k      = 0;
        int  stalls = 0;
        bit  pulsed = 0;
        cyc = 0;
        while (k < NB && cyc < 4000) begin
            check("valid", BW'(dout_valid), BW'(1));
            check("data", dout_data, exp_beat(k));
            check("core", BW'(dout_core), BW'(k / BPC));
            check("last", BW'(dout_last), BW'(k == NB - 1));
            check("clr_req", BW'(clr_req), BW'(cyc == 0));
            check("busy", BW'(busy), BW'(1));
            check("done_early", BW'(done), BW'(0));
            if (cyc == 0) din = '1;
            if (k == stop_at) return;
            dout_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            clk_en = 1'b1;
            start  = 1'b0;
            if (mode == 2 && k == 60 && stalls < 5) begin
                clk_en = 1'b0;
                stalls++;
            end
            if (mode == 2 && k == 40 && !pulsed) begin
                start  = 1'b1;
                pulsed = 1;
            end
            if (dout_ready && clk_en) k++;
            cyc++;
            @(negedge clk);
        end
        start  = 1'b0;
        clk_en = 1'b1;
        if (k < NB) begin
            check("drain_timeout", BW'(k), BW'(NB));
            return;
        end
        check("done_valid", BW'(dout_valid), BW'(0));
        check("done_pulse", BW'(done), BW'(1));
        check("done_busy", BW'(busy), BW'(1));
        @(negedge clk);
        check("post_done", BW'(done), BW'(0));
        check("post_busy", BW'(busy), BW'(0));
        check("post_valid", BW'(dout_valid), BW'(0));
    endtask

    initial begin
        int cyc;
        logic [W-1:0] relu_exp0;
        rst = 1'b1; clk_en = 1'b1; start = 1'b0; dout_ready = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", BW'(busy), BW'(0));
        check("rst_clr", BW'(clr_req), BW'(0));
        check("rst_valid", BW'(dout_valid), BW'(0));
        check("rst_last", BW'(dout_last), BW'(0));
        check("rst_done", BW'(done), BW'(0));
        check("rst_data", dout_data, BW'(0));
        check("rst_core", BW'(dout_core), BW'(0));
        rst = 1'b0;
        @(negedge clk);

        // Basic drain with a ramp and ready tied high; checks minimum latency.
        for (int n = 0; n < NPIX; n++) pix[n] = W'(n);
        load_din();
        do_start();
        drain(0, -1, cyc);
        check("latency", BW'(cyc), BW'(NB));

        // Backpressure.
        rand_pix(); load_din();
        do_start();
        drain(1, -1, cyc);

        // Ignored start and clk_en hold.
        rand_pix(); load_din();
        do_start();
        drain(2, -1, cyc);
        check("stall_cycles", BW'(cyc), BW'(NB + 5));

        // Reset mid-stream then a clean restart.
        rand_pix(); load_din();
        do_start();
        drain(0, 50, cyc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", BW'(dout_valid), BW'(0));
        check("mid_rst_busy", BW'(busy), BW'(0));
        check("mid_rst_done", BW'(done), BW'(0));
        check("mid_rst_data", dout_data, BW'(0));
        @(negedge clk);
        check("mid_rst_done2", BW'(done), BW'(0));
        rand_pix(); load_din();
        do_start();
        drain(0, -1, cyc);

        // Sign handling on lanes 0 and 1.
        rand_pix();
        pix[0] = 20'h80001;
        pix[1] = 20'h7FFFF;
        load_din();
        do_start();
`ifdef OFMS_DRAIN_RELU_EN
        relu_exp0 = 20'h00000;
`else
        relu_exp0 = 20'h80001;
`endif
        check("lane0", BW'(dout_data[W-1:0]), BW'(relu_exp0));
        check("lane1", BW'(dout_data[2*W-1:W]), BW'(20'h7FFFF));
        drain(0, -1, cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
